// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock-enable divider controller.
//   state_e     : controller FSM encoding (IDLE / RUN_ST / DRAIN)
//   MIN_DIV     : smallest accepted divide ratio
//   DEFAULT_DIV : ratio in effect after reset (4 -> 25 MHz from 100 MHz)
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN_ST = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    localparam int unsigned MIN_DIV     = 2;
    localparam int unsigned DEFAULT_DIV = 4;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Control/status bundle of the divider controller.
//   RUN      : level, 1 = generate output, 0 = stop at period end
//   DIV_IN   : requested divide ratio
//   DIV_LOAD : 1-cycle request to load DIV_IN
//   DIV_ACK  : 1-cycle pulse, requested ratio now in effect
//   DIV_ERR  : 1-cycle pulse, request below minimum and discarded
//   DIV_CUR  : ratio currently in effect
//   ACTIVE   : controller not idle
//   TICK     : 1-cycle strobe per divided period
//   CLKOUT   : divided square wave
// master = requester side, slave = divider controller.
interface clk_div_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic             RUN;
    logic [CNT_W-1:0] DIV_IN;
    logic             DIV_LOAD;
    logic             DIV_ACK;
    logic             DIV_ERR;
    logic [CNT_W-1:0] DIV_CUR;
    logic             ACTIVE;
    logic             TICK;
    logic             CLKOUT;

    modport master (
        output RUN, DIV_IN, DIV_LOAD,
        input  DIV_ACK, DIV_ERR, DIV_CUR, ACTIVE, TICK, CLKOUT
    );

    modport slave (
        input  RUN, DIV_IN, DIV_LOAD,
        output DIV_ACK, DIV_ERR, DIV_CUR, ACTIVE, TICK, CLKOUT
    );
endinterface

// File: rtl/clk_phase_cnt.sv
// Phase counter for the divider: counts 0..n_i-1 while enabled.
//   CLK, RST : clock, asynchronous active-high reset
//   clr_i    : force counter to 0 (has priority over en_i)
//   en_i     : advance counter
//   n_i      : divide ratio of the current period
//   wrap_o   : counter is at n_i-1 (next advance returns to 0)
//   half_o   : next advance lands on ceil(n_i/2), the falling point of CLKOUT
module clk_phase_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] n_i,
    output logic             wrap_o,
    output logic             half_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W:0]   half_pt;

    // One extra bit so N = 2**CNT_W-1 cannot overflow the comparisons.
    assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign half_pt = ({1'b0, n_i} + (CNT_W+1)'(1)) >> 1;
    assign wrap_o  = (cnt_inc == {1'b0, n_i});
    assign half_o  = (cnt_inc == half_pt);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= wrap_o ? '0 : cnt_inc[CNT_W-1:0];
        end
    end
endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller for the board clock-enable divider.
// Produces a divided square wave (CLKOUT, high ceil(N/2), low floor(N/2)) and a
// per-period strobe (TICK, coincident with the CLKOUT rising edge) from CLK.
// Stopping drains to the end of the current period; ratio reloads while running
// are held pending and applied only at a period boundary.
//   CLK : 100 MHz clock
//   RST : asynchronous active-high reset
//   bus : control/status bundle (slave side), see clk_div_ctrl_if
module clk_div_ctrl #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
    input  logic           CLK,
    input  logic           RST,
    clk_div_ctrl_if.slave  bus
);
    import clk_div_pkg::*;

    state_e           state_q, state_d;
    logic             tick_q, tick_d;
    logic             clkout_q, clkout_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] div_cur_q, div_cur_d;
    logic             pend_vld_q, pend_vld_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             load_ok, load_bad;
    logic             wrap, half;

    clk_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .CLK    (CLK),
        .RST    (RST),
        .clr_i  (state_q == IDLE),
        .en_i   (state_q != IDLE),
        .n_i    (div_cur_q),
        .wrap_o (wrap),
        .half_o (half)
    );

    always_comb begin
        load_bad   = bus.DIV_LOAD && (bus.DIV_IN < CNT_W'(MIN_DIV));
        load_ok    = bus.DIV_LOAD && !load_bad;
        state_d    = state_q;
        tick_d     = 1'b0;
        clkout_d   = clkout_q;
        ack_d      = 1'b0;
        err_d      = load_bad;
        div_cur_d  = div_cur_q;
        pend_vld_d = pend_vld_q;
        pend_div_d = pend_div_q;

        case (state_q)
            IDLE: begin
                clkout_d = 1'b0;
                // Applied before RUN so a same-cycle load shapes the first period.
                if (load_ok) begin
                    div_cur_d = bus.DIV_IN;
                    ack_d     = 1'b1;
                end
                if (bus.RUN) begin
                    state_d  = RUN_ST;
                    tick_d   = 1'b1;
                    clkout_d = 1'b1;
                end
            end
            RUN_ST, DRAIN: begin
                if (wrap) begin
                    // Period boundary: RUN decides between a new period and idle.
                    if (bus.RUN) begin
                        state_d  = RUN_ST;
                        tick_d   = 1'b1;
                        clkout_d = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        clkout_d = 1'b0;
                    end
                    if (pend_vld_q) begin
                        div_cur_d  = pend_div_q;
                        ack_d      = 1'b1;
                        pend_vld_d = 1'b0;
                    end
                end else begin
                    state_d = bus.RUN ? RUN_ST : DRAIN;
                    if (half) begin
                        clkout_d = 1'b0;
                    end
                end
                // A load on the wrap edge itself re-arms pending for the next wrap.
                if (load_ok) begin
                    pend_div_d = bus.DIV_IN;
                    pend_vld_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            tick_q     <= 1'b0;
            clkout_q   <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            div_cur_q  <= CNT_W'(DEFAULT_DIV);
            pend_vld_q <= 1'b0;
            pend_div_q <= '0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            clkout_q   <= clkout_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            div_cur_q  <= div_cur_d;
            pend_vld_q <= pend_vld_d;
            pend_div_q <= pend_div_d;
        end
    end

    assign bus.TICK    = tick_q;
    assign bus.CLKOUT  = clkout_q;
    assign bus.DIV_ACK = ack_q;
    assign bus.DIV_ERR = err_q;
    assign bus.DIV_CUR = div_cur_q;
    assign bus.ACTIVE  = (state_q != IDLE);
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: a period/phase model of the divider checked against
// the DUT every cycle, plus hand-computed expectations for directed scenarios.
module tb_clk_div_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b0;

    clk_div_ctrl_if #(.CNT_W(8)) bus ();

    clk_div_ctrl #(
        .CNT_W       (8),
        .DEFAULT_DIV (4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model: generating or not, phase within the current period, ratio,
    // pending ratio, and the expected one-cycle pulses.
    bit m_on  = 1'b0;
    int m_p   = 0;
    int m_n   = 4;
    bit m_pv  = 1'b0;
    int m_pn  = 0;
    bit e_ack = 1'b0;
    bit e_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit ok;
        if (RST) begin
            m_on = 1'b0; m_p = 0; m_n = 4; m_pv = 1'b0; e_ack = 1'b0; e_err = 1'b0;
        end else begin
            ok    = bus.DIV_LOAD && (bus.DIV_IN >= 2);
            e_err = bus.DIV_LOAD && (bus.DIV_IN < 2);
            e_ack = 1'b0;
            if (!m_on) begin
                if (ok) begin
                    m_n = int'(bus.DIV_IN); e_ack = 1'b1;
                end
                if (bus.RUN) begin
                    m_on = 1'b1; m_p = 0;
                end
            end else begin
                if (m_p == m_n - 1) begin
                    if (m_pv) begin
                        m_n = m_pn; m_pv = 1'b0; e_ack = 1'b1;
                    end
                    m_p  = 0;
                    m_on = bus.RUN;
                end else begin
                    m_p++;
                end
                if (ok) begin
                    m_pn = int'(bus.DIV_IN); m_pv = 1'b1;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge CLK or posedge RST);
        model_step();
    end

    initial forever begin
        @(negedge CLK);
        if (chk_en) begin
            chk("cycle", {19'd0, bus.ACTIVE, bus.TICK, bus.CLKOUT, bus.DIV_ACK, bus.DIV_ERR,
                          bus.DIV_CUR},
                {19'd0, m_on, (m_on && m_p == 0), (m_on && m_p < (m_n + 1) / 2), e_ack, e_err,
                 8'(m_n)});
        end
    end

    // Waits for the next TICK (at least one cycle); k = cycles waited.
    task automatic wait_tick(output int k);
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!bus.TICK && k < 64);
        chk("tick_seen", {31'd0, bus.TICK}, 32'd1);
    endtask

    task automatic count_cyc(input int n, output int acks, output int errs, output int ticks,
                             output int acts);
        acks = 0; errs = 0; ticks = 0; acts = 0;
        repeat (n) begin
            @(negedge CLK);
            acks  += int'(bus.DIV_ACK);
            errs  += int'(bus.DIV_ERR);
            ticks += int'(bus.TICK);
            acts  += int'(bus.ACTIVE);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int k, acks, errs, ticks, acts, errs_pre;
        logic [7:0] pat8;
        logic [9:0] pat10;

        bus.RUN = 1'b0; bus.DIV_IN = '0; bus.DIV_LOAD = 1'b0;
        #1 RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk_en = 1'b1;
        chk("rst_div_cur", {24'd0, bus.DIV_CUR}, 32'd4);
        chk("rst_active", {31'd0, bus.ACTIVE}, 32'd0);
        chk("rst_tick", {31'd0, bus.TICK}, 32'd0);
        chk("rst_clkout", {31'd0, bus.CLKOUT}, 32'd0);

        // N=4: first TICK one cycle after RUN, CLKOUT 2 high / 2 low.
        bus.RUN = 1'b1;
        @(negedge CLK);
        chk("first_tick", {31'd0, bus.TICK}, 32'd1);
        pat8 = '0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge CLK);
            pat8 = {pat8[6:0], bus.CLKOUT};
        end
        chk("n4_pattern", {24'd0, pat8}, 32'h000000cc);
        wait_tick(k);
        wait_tick(k);
        chk("n4_gap", k, 32'd4);

        // Load 8 at cnt=1: ACK with the next TICK, then gap 8.
        @(negedge CLK);
        bus.DIV_IN = 8'd8; bus.DIV_LOAD = 1'b1;
        @(negedge CLK);
        bus.DIV_LOAD = 1'b0;
        wait_tick(k);
        chk("n8_ack_at_wrap", {31'd0, bus.DIV_ACK}, 32'd1);
        chk("n8_div_cur", {24'd0, bus.DIV_CUR}, 32'd8);
        wait_tick(k);
        chk("n8_gap", k, 32'd8);

        // Load 6 then 10 before the wrap: one ACK, last wins.
        bus.DIV_IN = 8'd6; bus.DIV_LOAD = 1'b1;
        @(negedge CLK);
        bus.DIV_IN = 8'd10;
        @(negedge CLK);
        bus.DIV_LOAD = 1'b0;
        count_cyc(12, acks, errs, ticks, acts);
        chk("last_wins_acks", acks, 32'd1);
        chk("last_wins_div_cur", {24'd0, bus.DIV_CUR}, 32'd10);

        // N=5: CLKOUT 3 high / 2 low, TICK period 5, ACTIVE throughout.
        bus.DIV_IN = 8'd5; bus.DIV_LOAD = 1'b1;
        @(negedge CLK);
        bus.DIV_LOAD = 1'b0;
        wait_tick(k);
        pat10 = '0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge CLK);
            pat10 = {pat10[8:0], bus.CLKOUT};
        end
        chk("n5_pattern", {22'd0, pat10}, 32'h0000039c);
        wait_tick(k);
        count_cyc(5, acks, errs, ticks, acts);
        chk("n5_ticks", ticks, 32'd1);
        chk("n5_active", acts, 32'd5);

        // Ratios 1 and 0 are rejected.
        errs_pre = 0;
        bus.DIV_IN = 8'd1; bus.DIV_LOAD = 1'b1;
        @(negedge CLK);
        errs_pre += int'(bus.DIV_ERR);
        bus.DIV_IN = 8'd0;
        @(negedge CLK);
        errs_pre += int'(bus.DIV_ERR);
        bus.DIV_LOAD = 1'b0;
        count_cyc(8, acks, errs, ticks, acts);
        chk("err_pulses", errs + errs_pre, 32'd2);
        chk("err_no_ack", acks, 32'd0);
        chk("err_div_cur", {24'd0, bus.DIV_CUR}, 32'd5);

        // Back to N=4, stop at cnt=1: two DRAIN cycles, no extra TICK.
        bus.DIV_IN = 8'd4; bus.DIV_LOAD = 1'b1;
        @(negedge CLK);
        bus.DIV_LOAD = 1'b0;
        wait_tick(k);
        chk("n4_reload", {24'd0, bus.DIV_CUR}, 32'd4);
        @(negedge CLK);
        bus.RUN = 1'b0;
        count_cyc(6, acks, errs, ticks, acts);
        chk("drain_active", acts, 32'd2);
        chk("drain_ticks", ticks, 32'd0);
        chk("idle_clkout", {31'd0, bus.CLKOUT}, 32'd0);

        // Load pended during drain is applied on entry to IDLE.
        bus.RUN = 1'b1;
        wait_tick(k);
        @(negedge CLK);
        bus.RUN = 1'b0; bus.DIV_IN = 8'd6; bus.DIV_LOAD = 1'b1;
        @(negedge CLK);
        bus.DIV_LOAD = 1'b0;
        count_cyc(4, acks, errs, ticks, acts);
        chk("drain_pend_acks", acks, 32'd1);
        chk("drain_pend_div_cur", {24'd0, bus.DIV_CUR}, 32'd6);
        chk("drain_pend_idle", {31'd0, bus.ACTIVE}, 32'd0);

        // RUN and load together from IDLE: first period uses the new ratio.
        bus.RUN = 1'b1; bus.DIV_IN = 8'd3; bus.DIV_LOAD = 1'b1;
        @(negedge CLK);
        bus.DIV_LOAD = 1'b0;
        chk("start_load", {29'd0, bus.TICK, bus.DIV_ACK, 1'b0}, 32'd6);
        chk("start_load_div", {24'd0, bus.DIV_CUR}, 32'd3);
        wait_tick(k);
        chk("n3_gap", k, 32'd3);

        // Asynchronous reset mid-period.
        @(negedge CLK);
        #2 RST = 1'b1;
        bus.RUN = 1'b0;
        #1;
        chk("async_rst", {19'd0, bus.ACTIVE, bus.TICK, bus.CLKOUT, bus.DIV_ACK, bus.DIV_ERR,
                          bus.DIV_CUR}, 32'd4);
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
